// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command codes, arbiter and read-engine states, fixed addresses.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  localparam logic [1:0]  BANK_ADDR      = 2'b00;
  localparam logic [11:0] ADDR_ALL_BANKS = 12'h400;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ARBIT,
    ARB_AREF,
    ARB_WRITE,
    ARB_READ
  } arb_state_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ACT,
    S_READ,
    S_PRE
  } rd_state_t;

endpackage

// File: rtl/sdram_rd_capture.sv
// Aligns returned SDRAM read data: each READ opens a 4-beat window delayed by CAS_LAT+1 cycles.
// Runs independently of the command FSM so the tail of the last burst is still captured after PRE.
module sdram_rd_capture #(
  parameter int CAS_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_issue,
  input  logic [15:0] sdram_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  logic [1:0]       stretch;
  logic [CAS_LAT:0] vpipe;
  logic             beat;

  // High for the 4 cycles starting at the READ, one per burst word.
  assign beat = rd_issue | (stretch != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stretch <= 2'd0;
      vpipe   <= '0;
      rd_data <= 16'd0;
    end else begin
      if (rd_issue)
        stretch <= 2'd3;
      else if (stretch != 2'd0)
        stretch <= stretch - 2'd1;
      vpipe   <= {vpipe[CAS_LAT-1:0], beat};
      rd_data <= sdram_dq;
    end
  end

  assign rd_data_vld = vpipe[CAS_LAT];

endmodule

// File: rtl/sdram_read.sv
// SDRAM read-burst engine: requests the bus, opens a row, issues 4-word bursts,
// yields to refresh at burst boundaries and resumes at the next unread column.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int ROW_NUM = 2,
  parameter int COL_NUM = 512,
  parameter int CAS_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  output logic        rd_req,
  output logic        flag_rd_end,
  input  logic        ref_req,
  input  logic        rd_trig,
  output logic [3:0]  rd_cmd,
  output logic [11:0] rd_addr,
  output logic [1:0]  bank_addr,
  input  logic [15:0] sdram_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
);

  localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam logic [9:0]    COL_END  = 10'(COL_NUM);
  localparam logic [9:0]    LAST_COL = 10'(COL_NUM - 4);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROW_NUM - 1);

  rd_state_t     state, state_nxt;
  logic [1:0]    cnt;
  logic          busy;
  logic          ref_pend;
  logic [9:0]    col_cnt;
  logic [RW-1:0] row_cnt;
  logic          rd_issue;
  logic          row_done;
  logic          all_done;

  assign row_done = (col_cnt == COL_END);
  assign all_done = row_done && (row_cnt == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    rd_cmd      = CMD_NOP;
    rd_addr     = 12'd0;
    rd_req      = 1'b0;
    flag_rd_end = 1'b0;
    rd_issue    = 1'b0;
    case (state)
      S_IDLE: begin
        if (rd_trig && !busy)
          state_nxt = S_REQ;
      end
      S_REQ: begin
        rd_req = 1'b1;
        if (rd_en)
          state_nxt = S_ACT;
      end
      S_ACT: begin
        if (cnt == 2'd0) begin
          rd_cmd  = CMD_ACT;
          rd_addr = 12'(row_cnt);
        end
        if (cnt == 2'd2)
          state_nxt = S_READ;
      end
      S_READ: begin
        if (cnt == 2'd0) begin
          rd_cmd   = CMD_READ;
          rd_addr  = {3'b000, col_cnt[8:0]};
          rd_issue = 1'b1;
        end
        // Refresh is only honoured on a burst boundary.
        if (cnt == 2'd3 && (col_cnt == LAST_COL || ref_pend))
          state_nxt = S_PRE;
      end
      S_PRE: begin
        if (cnt == 2'd0) begin
          rd_cmd  = CMD_PRE;
          rd_addr = ADDR_ALL_BANKS;
        end
        if (cnt == 2'd2) begin
          flag_rd_end = 1'b1;
          state_nxt   = all_done ? S_IDLE : S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      busy     <= 1'b0;
      ref_pend <= 1'b0;
      col_cnt  <= 10'd0;
      row_cnt  <= '0;
    end else begin
      if (state_nxt != state || state == S_IDLE || state == S_REQ)
        cnt <= 2'd0;
      else
        cnt <= cnt + 2'd1;

      if (state == S_IDLE && rd_trig)
        busy <= 1'b1;
      else if (state == S_PRE && cnt == 2'd2 && all_done)
        busy <= 1'b0;

      if (ref_req)
        ref_pend <= 1'b1;
      else if ((state == S_PRE && cnt == 2'd0) || (state == S_REQ && rd_en))
        ref_pend <= 1'b0;

      if (state == S_READ && cnt == 2'd3)
        col_cnt <= col_cnt + 10'd4;
      else if (state == S_PRE && cnt == 2'd2 && row_done) begin
        col_cnt <= 10'd0;
        row_cnt <= all_done ? '0 : row_cnt + RW'(1);
      end
    end
  end

  assign bank_addr = BANK_ADDR;

  sdram_rd_capture #(
    .CAS_LAT (CAS_LAT)
  ) u_capture (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_issue    (rd_issue),
    .sdram_dq    (sdram_dq),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld)
  );

endmodule
